// File: rtl/cam_tx_emulator.sv
// rtl/cam_tx_emulator.sv - camera-bus transmitter stand-in with 4-register control slave
//
// Purpose:
//   Generates cam_clk, cam_pixel, cam_hsync and cam_vsync in the same form a
//   real camera presents them, so the capture path can be brought up and
//   tested in closed loop.
//   Frame geometry and test pattern are programmed through a small
//   register slave that uses the bus_enable/rw/acknowledge handshake.
//
// Ports:
//   clk, rst        main clock; reset is asynchronous and active-low
//   cam_clk         generated pixel clock, clk/(2*CLK_DIV)
//   cam_pixel[11:0] pixel data, updated only on cam_clk falling edges
//   cam_hsync       high while the current line's pixels are valid
//   cam_vsync       high from the first active line through the last one
//   tr_address[1:0] register index: 0 CTRL, 1 FCNT, 2 SIZE, 3 BLANK
//   tr_bus_enable   access request, acknowledged on the following cycle
//   tr_rw           1 = read, 0 = write
//   tr_write_data   write data
//   tr_read_data    read data, valid with tr_acknowledge, otherwise 0
//   tr_acknowledge  registered one-cycle access acknowledge
//
// Optional feature:
//   CAM_TX_LFSR_EN  when defined, CTRL[3] selects a 12-bit LFSR pattern.
module cam_tx_emulator #(
  parameter int CLK_DIV    = 2,
  parameter int DEF_WIDTH  = 640,
  parameter int DEF_HEIGHT = 480,
  parameter int DEF_HBLANK = 32,
  parameter int DEF_VBLANK = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        cam_clk,
  output logic [11:0] cam_pixel,
  output logic        cam_hsync,
  output logic        cam_vsync,
  input  logic [1:0]  tr_address,
  input  logic        tr_bus_enable,
  input  logic        tr_rw,
  input  logic [31:0] tr_write_data,
  output logic [31:0] tr_read_data,
  output logic        tr_acknowledge
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VBLANK,
    S_HBLANK,
    S_ACTIVE,
    S_FRAME_END
  } state_t;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [31:0] SIZE_DEF  = {16'(DEF_HEIGHT), 16'(DEF_WIDTH)};
  localparam logic [31:0] BLANK_DEF = {16'(DEF_VBLANK), 16'(DEF_HBLANK)};

  // Clock divider
  logic [15:0] div_q, div_d;
  logic        cam_clk_q, cam_clk_d;
  logic        tick;

  // Registers
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] size_q, size_d;
  logic [31:0] blank_q, blank_d;

  // Geometry frozen at frame start
  logic [15:0] sw_q, sw_d;
  logic [15:0] sh_q, sh_d;
  logic [15:0] shb_q, shb_d;
  logic [15:0] svb_q, svb_d;

  // Timing FSM
  state_t      state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [16:0] pcnt_q, pcnt_d;
  logic [15:0] lcnt_q, lcnt_d;
  logic [16:0] line_len;
  logic        frame_start;
  logic        enter_line;

  // Registered outputs
  logic [11:0] pix_q, pix_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;

`ifdef CAM_TX_LFSR_EN
  localparam logic [11:0] LFSR_SEED = 12'hACE;
  logic [11:0] lfsr_q, lfsr_d, lfsr_cur;
`endif

  always_comb begin
    div_d       = div_q;
    cam_clk_d   = cam_clk_q;
    ctrl_d      = ctrl_q;
    fcnt_d      = fcnt_q;
    size_d      = size_q;
    blank_d     = blank_q;
    sw_d        = sw_q;
    sh_d        = sh_q;
    shb_d       = shb_q;
    svb_d       = svb_q;
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    pcnt_d      = pcnt_q;
    lcnt_d      = lcnt_q;
    pix_d       = pix_q;
    hs_d        = hs_q;
    vs_d        = vs_q;
    ack_d       = tr_bus_enable;
    rdata_d     = 32'h0;
    frame_start = 1'b0;
    enter_line  = 1'b0;
    line_len    = {1'b0, sw_q} + {1'b0, shb_q};
`ifdef CAM_TX_LFSR_EN
    lfsr_d      = lfsr_q;
    lfsr_cur    = lfsr_q;
`endif

    // cam_clk free-runs; a tick is the clk on which it falls.
    tick = cam_clk_q && (div_q == DIV_LAST);
    if (div_q == DIV_LAST) begin
      div_d     = 16'h0;
      cam_clk_d = ~cam_clk_q;
    end else begin
      div_d = div_q + 16'd1;
    end

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (ctrl_q[0]) frame_start = 1'b1;
        end
        S_VBLANK: begin
          // Blank lines are counted as (width+hblank)-period rows.
          if (pcnt_q == line_len - 17'd1) begin
            pcnt_d = 17'h0;
            if (lcnt_q == svb_q - 16'd1) enter_line = 1'b1;
            else lcnt_d = lcnt_q + 16'd1;
          end else begin
            pcnt_d = pcnt_q + 17'd1;
          end
        end
        S_HBLANK: begin
          if (pcnt_q == {1'b0, shb_q} - 17'd1) begin
            state_d = S_ACTIVE;
            x_d     = 16'h0;
          end else begin
            pcnt_d = pcnt_q + 17'd1;
          end
        end
        S_ACTIVE: begin
          if (x_q == sw_q - 16'd1) begin
            if (y_q == sh_q - 16'd1) begin
              state_d = S_FRAME_END;
              fcnt_d  = fcnt_q + 32'd1;
            end else begin
              y_d        = y_q + 16'd1;
              enter_line = 1'b1;
            end
          end else begin
            x_d = x_q + 16'd1;
          end
        end
        S_FRAME_END: begin
          // Enable is only honoured here, so frames are never truncated.
          if (ctrl_q[0] && !ctrl_q[2]) begin
            frame_start = 1'b1;
          end else begin
            state_d = S_IDLE;
            if (ctrl_q[2]) begin
              ctrl_d[0] = 1'b0;
              ctrl_d[2] = 1'b0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (enter_line) begin
        if (shb_q != 16'h0) begin
          state_d = S_HBLANK;
          pcnt_d  = 17'h0;
        end else begin
          state_d = S_ACTIVE;
          x_d     = 16'h0;
        end
      end

      // Shadow takes the pre-write register value if a write lands now.
      if (frame_start) begin
        sw_d   = (size_q[15:0] == 16'h0) ? 16'd1 : size_q[15:0];
        sh_d   = (size_q[31:16] == 16'h0) ? 16'd1 : size_q[31:16];
        shb_d  = blank_q[15:0];
        svb_d  = blank_q[31:16];
        x_d    = 16'h0;
        y_d    = 16'h0;
        pcnt_d = 17'h0;
        lcnt_d = 16'h0;
        if (blank_q[31:16] != 16'h0)     state_d = S_VBLANK;
        else if (blank_q[15:0] != 16'h0) state_d = S_HBLANK;
        else                             state_d = S_ACTIVE;
`ifdef CAM_TX_LFSR_EN
        lfsr_cur = LFSR_SEED;
        lfsr_d   = LFSR_SEED;
`endif
      end

      hs_d = (state_d == S_ACTIVE);
      vs_d = (state_d == S_ACTIVE) || (state_d == S_HBLANK);
      if (state_d == S_ACTIVE) begin
`ifdef CAM_TX_LFSR_EN
        if (ctrl_q[3]) begin
          pix_d  = lfsr_cur;
          lfsr_d = {lfsr_cur[10:0], lfsr_cur[11] ^ lfsr_cur[10] ^ lfsr_cur[9] ^ lfsr_cur[3]};
        end else
`endif
        if (ctrl_q[1]) pix_d = (x_d[3] ^ y_d[3]) ? 12'hFFF : 12'h000;
        else           pix_d = x_d[11:0] + y_d[11:0] + fcnt_q[11:0];
      end else begin
        pix_d = 12'h000;
      end
    end

    // Register writes come last so a CPU write beats the single-shot clear.
    if (tr_bus_enable && !tr_rw) begin
      case (tr_address)
`ifdef CAM_TX_LFSR_EN
        2'd0: ctrl_d = tr_write_data[3:0];
`else
        2'd0: ctrl_d = {1'b0, tr_write_data[2:0]};
`endif
        2'd2: size_d  = tr_write_data;
        2'd3: blank_d = tr_write_data;
        default: ;
      endcase
    end

    if (tr_bus_enable && tr_rw) begin
      case (tr_address)
        2'd0:    rdata_d = {28'h0, ctrl_q};
        2'd1:    rdata_d = fcnt_q;
        2'd2:    rdata_d = size_q;
        default: rdata_d = blank_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q     <= 16'h0;
      cam_clk_q <= 1'b0;
      ctrl_q    <= 4'h0;
      fcnt_q    <= 32'h0;
      size_q    <= SIZE_DEF;
      blank_q   <= BLANK_DEF;
      sw_q      <= SIZE_DEF[15:0];
      sh_q      <= SIZE_DEF[31:16];
      shb_q     <= BLANK_DEF[15:0];
      svb_q     <= BLANK_DEF[31:16];
      state_q   <= S_IDLE;
      x_q       <= 16'h0;
      y_q       <= 16'h0;
      pcnt_q    <= 17'h0;
      lcnt_q    <= 16'h0;
      pix_q     <= 12'h0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= 32'h0;
`ifdef CAM_TX_LFSR_EN
      lfsr_q    <= LFSR_SEED;
`endif
    end else begin
      div_q     <= div_d;
      cam_clk_q <= cam_clk_d;
      ctrl_q    <= ctrl_d;
      fcnt_q    <= fcnt_d;
      size_q    <= size_d;
      blank_q   <= blank_d;
      sw_q      <= sw_d;
      sh_q      <= sh_d;
      shb_q     <= shb_d;
      svb_q     <= svb_d;
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pcnt_q    <= pcnt_d;
      lcnt_q    <= lcnt_d;
      pix_q     <= pix_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
`ifdef CAM_TX_LFSR_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

  assign cam_clk        = cam_clk_q;
  assign cam_pixel      = pix_q;
  assign cam_hsync      = hs_q;
  assign cam_vsync      = vs_q;
  assign tr_acknowledge = ack_q;
  assign tr_read_data   = rdata_q;

endmodule
